vending_coin_sequencer: RTL and testbench

- Controller placed in front of the two-product vending core.
- Collects coins from N independent coin-acceptor slots over valid/ready handshakes and arbitrates them round-robin.
- Serialises each accepted coin into a single-cycle d1 (0.5) or d2 (1.0) pulse to the core, and holds the product select stable for the whole transaction.
- Tracks credit, then waits for the core's dispense/change outputs before releasing the next transaction.

---
 rtl/vending_pkg.sv | 27 ++
 rtl/vending_coin_sequencer_if.sv | 11 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/vending_coin_sequencer.sv | 152 +++++++++++++++
 tb/tb_vending_coin_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending coin sequencer.
// Credit and prices are counted in half-units.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic COIN_HALF = 1'b0;
  localparam logic COIN_ONE  = 1'b1;

  localparam int CREDIT_W = 3;
  localparam logic [CREDIT_W-1:0] PRICE_P1 = 3'd2;
  localparam logic [CREDIT_W-1:0] PRICE_P2 = 3'd4;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic coin);
    return (coin == COIN_HALF) ? 3'd1 : 3'd2;
  endfunction

  function automatic logic [CREDIT_W-1:0] price_of(input logic sel);
    return sel ? PRICE_P2 : PRICE_P1;
  endfunction

endpackage

// File: rtl/vending_coin_sequencer_if.sv
// Coin-acceptor slot bus: per-slot valid/coin from the acceptors, one-hot ready back.
interface vending_coin_sequencer_if #(
  parameter int N_SLOT = 2
);
  logic [N_SLOT-1:0] slot_vld;
  logic [N_SLOT-1:0] slot_coin;
  logic [N_SLOT-1:0] slot_rdy;

  modport master (output slot_vld, output slot_coin, input slot_rdy);
  modport slave  (input slot_vld, input slot_coin, output slot_rdy);
endinterface

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational grant searching from ptr+1,
// pointer moves to the granted slot only when the caller accepts.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 upd,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_reg;
  int               cand;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= N) cand = cand - N;
      if (!gnt_any && req[IDX_W'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign gnt[gi] = gnt_any && (gnt_idx == IDX_W'(gi));
  end

  // Reset to the last slot so slot 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg <= IDX_W'(N - 1);
    end else if (upd) begin
      ptr_reg <= gnt_idx;
    end
  end

endmodule

// File: rtl/vending_coin_sequencer.sv
// Front-end for the two-product vending core: arbitrates coin slots, serialises
// each coin into a d1/d2 pulse, tracks credit and waits for the core's dispense.
module vending_coin_sequencer
  import vending_pkg::*;
#(
  parameter int N_SLOT    = 2,
  parameter int GAP_CYC   = 2,
  parameter int DRAIN_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  vending_coin_sequencer_if.slave slots,
  input  logic                    sel_req,
  input  logic                    vm_out1,
  input  logic                    vm_out2,
  input  logic                    vm_out3,
  output logic                    vm_d1,
  output logic                    vm_d2,
  output logic                    vm_sel,
  output logic                    busy,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    done,
  output logic                    change,
  output logic                    err
);
  localparam int IDX_W   = $clog2(N_SLOT);
  localparam int CNT_MAX = (GAP_CYC > DRAIN_MAX) ? GAP_CYC : DRAIN_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                coin_reg;
  logic [CREDIT_W-1:0] credit_reg;
  logic                vm_d1_reg;
  logic                vm_d2_reg;
  logic                vm_sel_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                change_reg;
  logic                err_reg;

  logic [N_SLOT-1:0]   gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic                accept_win;
  logic                accept;
  logic                coin_in;
  logic [CREDIT_W-1:0] credit_next;
  logic [CREDIT_W-1:0] price;

  rr_arbiter #(
    .N (N_SLOT)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (slots.slot_vld),
    .upd     (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Slots may only be accepted in IDLE or once the inter-coin gap has elapsed.
  always_comb begin
    accept_win  = rst && ((state_reg == IDLE) || ((state_reg == GAP) && (cnt_reg == '0)));
    accept      = accept_win && gnt_any;
    coin_in     = slots.slot_coin[gnt_idx];
    credit_next = credit_reg + coin_value(coin_reg);
    price       = price_of(vm_sel_reg);
  end

  assign slots.slot_rdy = accept_win ? gnt : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      coin_reg   <= COIN_HALF;
      credit_reg <= '0;
      vm_d1_reg  <= 1'b0;
      vm_d2_reg  <= 1'b0;
      vm_sel_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      change_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      vm_d1_reg  <= 1'b0;
      vm_d2_reg  <= 1'b0;
      done_reg   <= 1'b0;
      change_reg <= 1'b0;
      err_reg    <= 1'b0;

      case (state_reg)
        IDLE: begin
          vm_sel_reg <= sel_req;
        end
        PULSE: begin
          credit_reg <= credit_next;
          if (credit_next >= price) begin
            state_reg <= DRAIN;
            cnt_reg   <= '0;
          end else begin
            state_reg <= GAP;
            cnt_reg   <= CNT_W'(GAP_CYC);
          end
        end
        GAP: begin
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CNT_W'(1);
        end
        DRAIN: begin
          if (vm_out1 || vm_out2) begin
            done_reg   <= 1'b1;
            change_reg <= vm_out3;
            credit_reg <= '0;
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            state_reg  <= IDLE;
          end else if (cnt_reg == CNT_W'(DRAIN_MAX - 1)) begin
            err_reg    <= 1'b1;
            credit_reg <= '0;
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            state_reg  <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase

      // An accept overrides the per-state update; select stays frozen after the first coin.
      if (accept) begin
        coin_reg  <= coin_in;
        busy_reg  <= 1'b1;
        vm_d1_reg <= (coin_in == COIN_HALF);
        vm_d2_reg <= (coin_in == COIN_ONE);
        state_reg <= PULSE;
      end
    end
  end

  assign vm_d1  = vm_d1_reg;
  assign vm_d2  = vm_d2_reg;
  assign vm_sel = vm_sel_reg;
  assign busy   = busy_reg;
  assign credit = credit_reg;
  assign done   = done_reg;
  assign change = change_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_vending_coin_sequencer.sv
// Scoreboard bench for vending_coin_sequencer: directed coin sequences push expected
// grant/pulse/done/err events; a monitor pops and compares them as the DUT emits them.
module tb_vending_coin_sequencer;
  localparam int N_SLOT    = 2;
  localparam int GAP_CYC   = 2;
  localparam int DRAIN_MAX = 4;

  localparam int EV_GRANT = 0;
  localparam int EV_PULSE = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERR   = 3;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] a;
    logic       b;
    logic [2:0] cr;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel_req = 1'b0;
  logic       vm_out1 = 1'b0;
  logic       vm_out2 = 1'b0;
  logic       vm_out3 = 1'b0;
  logic       vm_d1, vm_d2, vm_sel, busy, done, change, err;
  logic [2:0] credit;

  ev_t exp_q[$];
  bit  s0_q[$];
  bit  s1_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  bit  core_en = 1'b1;

  vending_coin_sequencer_if #(.N_SLOT(N_SLOT)) bus ();

  vending_coin_sequencer #(
    .N_SLOT    (N_SLOT),
    .GAP_CYC   (GAP_CYC),
    .DRAIN_MAX (DRAIN_MAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .slots   (bus),
    .sel_req (sel_req),
    .vm_out1 (vm_out1),
    .vm_out2 (vm_out2),
    .vm_out3 (vm_out3),
    .vm_d1   (vm_d1),
    .vm_d2   (vm_d2),
    .vm_sel  (vm_sel),
    .busy    (busy),
    .credit  (credit),
    .done    (done),
    .change  (change),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int a, input int b, input int cr);
    ev_t e;
    e.kind = 2'(kind);
    e.a    = 4'(a);
    e.b    = 1'(b);
    e.cr   = 3'(cr);
    exp_q.push_back(e);
  endtask

  task automatic pop_ev(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: observed kind %0d, expected no event (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, int'(e.kind));
      ok = (int'(e.kind) == kind);
    end
  endtask

  // Monitor: compares DUT events against the scoreboard at the negative edge.
  initial begin
    ev_t e;
    bit  ok;
    bit  pend;
    int  pend_cr;
    int  last_pulse;
    int  idx;
    pend = 1'b0;
    pend_cr = 0;
    last_pulse = -100;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        chk("credit_after_pulse", int'(credit), pend_cr);
        pend = 1'b0;
      end
      if (done || err) begin
        pop_ev(done ? EV_DONE : EV_ERR, e, ok);
        if (ok) begin
          if (done) chk("done_change", int'(change), int'(e.a));
          else chk("err_delay", cyc - last_pulse, DRAIN_MAX + 1);
          chk("credit_cleared", int'(credit), 0);
          chk("busy_cleared", int'(busy), 0);
        end
      end
      if (bus.slot_rdy != '0) begin
        chk("rdy_onehot", $countones(bus.slot_rdy), 1);
        idx = 0;
        for (int i = 0; i < N_SLOT; i++) if (bus.slot_rdy[i]) idx = i;
        pop_ev(EV_GRANT, e, ok);
        if (ok) chk("grant_slot", idx, int'(e.a));
      end
      if (vm_d1 || vm_d2) begin
        pop_ev(EV_PULSE, e, ok);
        if (ok) begin
          chk("pulse_d1d2", int'({vm_d1, vm_d2}), e.a[0] ? 1 : 2);
          chk("pulse_vm_sel", int'(vm_sel), int'(e.b));
          chk("pulse_spacing_ok", int'((cyc - last_pulse) >= GAP_CYC + 1), 1);
          pend    = 1'b1;
          pend_cr = int'(e.cr);
        end
        last_pulse = cyc;
      end
    end
  end

  // Coin acceptors: each slot presents the head of its queue until accepted.
  initial begin
    bit acc0, acc1;
    bus.slot_vld  = '0;
    bus.slot_coin = '0;
    forever begin
      @(negedge clk);
      acc0 = bus.slot_rdy[0] & bus.slot_vld[0];
      acc1 = bus.slot_rdy[1] & bus.slot_vld[1];
      @(posedge clk);
      #1;
      if (acc0) s0_q.delete(0);
      if (acc1) s1_q.delete(0);
      bus.slot_vld[0]  = (s0_q.size() > 0);
      bus.slot_coin[0] = (s0_q.size() > 0) ? s0_q[0] : 1'b0;
      bus.slot_vld[1]  = (s1_q.size() > 0);
      bus.slot_coin[1] = (s1_q.size() > 0) ? s1_q[0] : 1'b0;
    end
  end

  // Vending core model: dispenses 2 cycles after the pulse that reaches the price.
  initial begin
    int cc, fire, pr;
    bit chg, which;
    cc = 0; fire = 0; pr = 0; chg = 1'b0; which = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cc = 0;
        fire = 0;
      end else if (vm_d1 || vm_d2) begin
        cc += vm_d2 ? 2 : 1;
        pr = vm_sel ? 4 : 2;
        if (cc >= pr) begin
          fire  = 2;
          chg   = (cc > pr);
          which = vm_sel;
          cc    = 0;
        end
      end
      @(posedge clk);
      #1;
      vm_out1 = 1'b0;
      vm_out2 = 1'b0;
      vm_out3 = 1'b0;
      if (fire > 0) begin
        fire--;
        if (fire == 0 && core_en) begin
          vm_out1 = !which;
          vm_out2 = which;
          vm_out3 = chg;
        end
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy || s0_q.size() != 0 || s1_q.size() != 0) && n < 400);
    if (n >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: observed %0d pending events, expected 0", tag, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_pulse(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(vm_d1 || vm_d2) && n < 100);
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_pulse_timeout: observed no pulse, expected one within 100 cycles", tag);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_vm_d1", int'(vm_d1), 0);
    chk("rst_vm_d2", int'(vm_d2), 0);
    chk("rst_vm_sel", int'(vm_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_change", int'(change), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_slot_rdy", int'(bus.slot_rdy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // T1: coin 1.0 queued on slot 0 during reset, product1
    rst = 1'b0;
    sel_req = 1'b0;
    s0_q.push_back(1'b1);
    push_ev(EV_GRANT, 0, 0, 0);
    push_ev(EV_PULSE, 1, 0, 2);
    push_ev(EV_DONE, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_reset_state();
    go();
    rst = 1'b1;
    wait_quiet("t1");

    // T2: product2, slot 1 coins 0.5, 1.0, 1.0 -> credit 1, 3, 5 with change
    go();
    sel_req = 1'b1;
    s1_q.push_back(1'b0); s1_q.push_back(1'b1); s1_q.push_back(1'b1);
    push_ev(EV_GRANT, 1, 0, 0); push_ev(EV_PULSE, 0, 1, 1);
    push_ev(EV_GRANT, 1, 0, 0); push_ev(EV_PULSE, 1, 1, 3);
    push_ev(EV_GRANT, 1, 0, 0); push_ev(EV_PULSE, 1, 1, 5);
    push_ev(EV_DONE, 1, 0, 0);
    wait_quiet("t2");

    // T3: both slots hold 0.5 coins, product2 -> grants alternate 0,1,0,1
    go();
    s0_q.push_back(1'b0); s0_q.push_back(1'b0);
    s1_q.push_back(1'b0); s1_q.push_back(1'b0);
    push_ev(EV_GRANT, 0, 0, 0); push_ev(EV_PULSE, 0, 1, 1);
    push_ev(EV_GRANT, 1, 0, 0); push_ev(EV_PULSE, 0, 1, 2);
    push_ev(EV_GRANT, 0, 0, 0); push_ev(EV_PULSE, 0, 1, 3);
    push_ev(EV_GRANT, 1, 0, 0); push_ev(EV_PULSE, 0, 1, 4);
    push_ev(EV_DONE, 0, 0, 0);
    wait_quiet("t3");

    // T4: sel_req flips to product2 mid-transaction; select stays frozen at 0
    go();
    sel_req = 1'b0;
    s0_q.push_back(1'b0); s0_q.push_back(1'b0);
    push_ev(EV_GRANT, 0, 0, 0); push_ev(EV_PULSE, 0, 0, 1);
    push_ev(EV_GRANT, 0, 0, 0); push_ev(EV_PULSE, 0, 0, 2);
    push_ev(EV_DONE, 0, 0, 0);
    wait_pulse("t4");
    go();
    sel_req = 1'b1;
    wait_quiet("t4a");
    chk("vm_sel_tracks_idle", int'(vm_sel), 1);
    go();
    s1_q.push_back(1'b1); s1_q.push_back(1'b1);
    push_ev(EV_GRANT, 1, 0, 0); push_ev(EV_PULSE, 1, 1, 2);
    push_ev(EV_GRANT, 1, 0, 0); push_ev(EV_PULSE, 1, 1, 4);
    push_ev(EV_DONE, 0, 0, 0);
    wait_quiet("t4b");

    // T5: core never dispenses -> err DRAIN_MAX cycles into DRAIN
    go();
    core_en = 1'b0;
    sel_req = 1'b0;
    s0_q.push_back(1'b1);
    push_ev(EV_GRANT, 0, 0, 0); push_ev(EV_PULSE, 1, 0, 2);
    push_ev(EV_ERR, 0, 0, 0);
    wait_quiet("t5");
    go();
    core_en = 1'b1;

    // T6: reset while in GAP with credit 1, then both slots request
    sel_req = 1'b1;
    s1_q.push_back(1'b0);
    push_ev(EV_GRANT, 1, 0, 0); push_ev(EV_PULSE, 0, 1, 1);
    wait_pulse("t6");
    go();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    go();
    rst = 1'b1;
    sel_req = 1'b0;
    s0_q.push_back(1'b1);
    s1_q.push_back(1'b1);
    push_ev(EV_GRANT, 0, 0, 0); push_ev(EV_PULSE, 1, 0, 2);
    push_ev(EV_DONE, 0, 0, 0);
    push_ev(EV_GRANT, 1, 0, 0); push_ev(EV_PULSE, 1, 0, 2);
    push_ev(EV_DONE, 0, 0, 0);
    wait_quiet("t6");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
